multicycle_control: RTL and testbench
=====================================

# multicycle_control

Moore-style control FSM for the multicycle RV32I core. It sequences the shared datapath (single ALU, unified memory port, immediate extender, register file) through fetch, decode, execute, memory and writeback steps. It drives `ImmSrc` to the immediate extender using the core's existing encoding. It stalls on a memory ready handshake and keeps a retired-instruction counter.

## Interface
Parameters:
- `DATA_WIDTH`, 32: width of `instr` and `instret`.

Ports:
- `clk`  in  1  core clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `instr`  in  DATA_WIDTH  instruction register contents; stable from DECODE onward.
- `Zero`  in  1  ALU zero flag from the current cycle's ALU result.
- `mem_ready`  in  1  memory port completes the access this cycle.
- `PCWrite`  out  1  load PC.
- `AdrSrc`  out  1  memory address: 0 = PC, 1 = ALUOut.
- `MemWrite`  out  1  memory write strobe.
- `IRWrite`  out  1  load IR and OldPC.
- `RegWrite`  out  1  register file write.
- `ResultSrc`  out  2  00 ALUOut, 01 mem data reg, 10 ALU result, 11 ImmExt.
- `ALUSrcA`  out  2  00 PC, 01 OldPC, 10 rs1.
- `ALUSrcB`  out  2  00 rs2, 01 ImmExt, 10 constant 4.
- `ALUControl`  out  3  000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt.
- `ImmSrc`  out  3  000 I, 001 S, 010 B, 011 U, 100 J.
- `illegal`  out  1  one-cycle pulse on an unsupported opcode.
- `instret`  out  DATA_WIDTH  count of retired instructions.

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, LUI.
- Outputs are a pure decode of state, `instr`, `Zero` and `mem_ready`. Unlisted outputs are 0. ALUControl defaults to add.
- ImmSrc is always decoded from `instr[6:0]`:
  - 0000011 or 0010011: 000
  - 0100011: 001
  - 1100011: 010
  - 0110111: 011
  - 1101111: 100
  - otherwise: 000
- FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ResultSrc=10. IRWrite=PCWrite=`mem_ready`. Stays in FETCH while `mem_ready`=0, otherwise goes to DECODE.
- DECODE: ALUSrcA=01, ALUSrcB=01, add (precomputes branch/jump target). Next state by opcode:
  - lw/sw: MEMADR
  - R-type 0110011: EXECR
  - I-ALU 0010011: EXECI
  - 1100011: BRANCH
  - 1101111: JAL
  - 0110111: LUI
  - else: pulse `illegal`, go to FETCH
- MEMADR: ALUSrcA=10, ALUSrcB=01, add. lw goes to MEMREAD, sw to MEMWRITE.
- MEMREAD: AdrSrc=1, ResultSrc=00. Holds until `mem_ready`, then MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, then FETCH.
- MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1. Holds until `mem_ready`, then FETCH.
- EXECR: ALUSrcA=10, ALUSrcB=00, then ALUWB. ALU op from funct3:
  - 000: add, or sub when `instr[30]`=1
  - 100: xor
  - 110: or
  - 111: and
  - 010: slt
- EXECI: ALUSrcA=10, ALUSrcB=01, then ALUWB. Same funct3 map, except 000 is always add.
- ALUWB: ResultSrc=00, RegWrite=1, then FETCH.
- BRANCH: ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00, then FETCH. PCWrite = `Zero` for funct3 000 (beq), `!Zero` for 001 (bne), 0 otherwise.
- JAL: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1, then ALUWB.
- LUI: ResultSrc=11, RegWrite=1, then FETCH.
- instret increments by 1, wrapping at all-ones to 0, on each transition into FETCH from MEMWB, MEMWRITE, ALUWB, BRANCH or LUI. Illegal opcodes do not count.

## Timing
- Reset (rst_n low, asynchronous): state=FETCH, instret=0, illegal=0. All other outputs are the FETCH decode; with `mem_ready`=0 that means PCWrite=IRWrite=0.
- Deassertion takes effect at the first rising edge with rst_n high.
- Reset mid-instruction aborts it immediately. No writes are issued after reset asserts, and instret is not incremented.
- Cycles per instruction with `mem_ready` constantly 1:
  - lw: 5
  - sw: 4
  - R-type, I-ALU, jal: 4
  - branch, lui: 3
  - illegal: 2
- Each cycle of `mem_ready`=0 in FETCH, MEMREAD or MEMWRITE adds exactly one cycle. MemWrite stays high throughout a MEMWRITE stall.
- `Zero` is sampled combinationally in the BRANCH cycle only.

## Test plan
- Reset with `mem_ready`=1, then feed `add x3,x1,x2` (0x002081B3): states FETCH, DECODE, EXECR, ALUWB. ALUControl=000 in EXECR, RegWrite=1 in ALUWB, instret=1 after 4 cycles.
- Feed `sub` (0x402081B3): ALUControl=001 in EXECR. Feed `lw` with `mem_ready` low for 2 cycles in MEMREAD: 7 cycles total, RegWrite only in MEMWB, ImmSrc=000.
- `sw` (0x0020A223): ImmSrc=001, MemWrite=1 for exactly the MEMWRITE cycle(s), 4 cycles.
- `beq` (0x00208463): with Zero=1, PCWrite=1 in BRANCH; with Zero=0, PCWrite=0. ImmSrc=010. `bne` inverts both outcomes.
- `jal` (0x008000EF): ImmSrc=100, PCWrite=1 in JAL, RegWrite=1 in ALUWB. `lui` (0x123452B7): ImmSrc=011, ResultSrc=11, 3 cycles.
- Opcode 0x0000007F gives `illegal`=1 for one cycle, then FETCH with instret unchanged. Assert rst_n=0 during MEMWRITE: MemWrite drops the same cycle, state=FETCH, instret=0. Preload instret all-ones and retire one instruction: instret=0.

Source files
------------

// File: rtl/multicycle_control.sv
// multicycle_control
//   Moore-style sequencer for the multicycle RV32I core. It steps the shared
//   datapath (one ALU, one memory port, immediate extender, register file)
//   through fetch, decode, execute, memory and writeback. It also keeps a
//   count of retired instructions.
//
// Ports
//   clk, rst_n  : core clock (rising edge); asynchronous active-low reset
//   instr       : instruction register contents, stable from DECODE onward
//   Zero        : ALU zero flag for this cycle's ALU result
//   mem_ready   : the memory port completes its access this cycle
//   PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite  : datapath strobes/selects
//   ResultSrc, ALUSrcA, ALUSrcB, ALUControl        : datapath mux/op selects
//   ImmSrc      : immediate format for the extender (I/S/B/U/J)
//   illegal     : one-cycle pulse when DECODE sees an unsupported opcode
//   instret     : retired-instruction counter, wraps from all-ones to 0
module multicycle_control #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] instr,
  input  logic                  Zero,
  input  logic                  mem_ready,
  output logic                  PCWrite,
  output logic                  AdrSrc,
  output logic                  MemWrite,
  output logic                  IRWrite,
  output logic                  RegWrite,
  output logic [1:0]            ResultSrc,
  output logic [1:0]            ALUSrcA,
  output logic [1:0]            ALUSrcB,
  output logic [2:0]            ALUControl,
  output logic [2:0]            ImmSrc,
  output logic                  illegal,
  output logic [DATA_WIDTH-1:0] instret
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECR    = 4'd6;
  localparam logic [3:0] S_EXECI    = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BRANCH   = 4'd9;
  localparam logic [3:0] S_JAL      = 4'd10;
  localparam logic [3:0] S_LUI      = 4'd11;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  logic [3:0]            state;
  logic [3:0]            state_next;
  logic [DATA_WIDTH-1:0] instret_q;
  logic                  retire;
  logic [6:0]            opcode;
  logic [2:0]            funct3;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];

  // Instruction bits the controller does not look at (registers, immediates).
  logic unused_instr_bits;
  assign unused_instr_bits = ^{instr[DATA_WIDTH-1:31], instr[29:15], instr[11:7]};

  // Immediate format depends only on the opcode, so the extender is already
  // correct during DECODE when the branch/jump target is precomputed.
  function automatic logic [2:0] imm_src_dec(input logic [6:0] op);
    case (op)
      OP_LOAD, OP_ITYPE: imm_src_dec = 3'b000;
      OP_STORE:          imm_src_dec = 3'b001;
      OP_BRANCH:         imm_src_dec = 3'b010;
      OP_LUI:            imm_src_dec = 3'b011;
      OP_JAL:            imm_src_dec = 3'b100;
      default:           imm_src_dec = 3'b000;
    endcase
  endfunction

  // funct3 -> ALU op. sub_ok is only set for R-type, because for I-type
  // instructions bit 30 belongs to the immediate.
  function automatic logic [2:0] alu_dec(input logic [2:0] f3, input logic sub_ok);
    case (f3)
      3'b000:  alu_dec = sub_ok ? ALU_SUB : ALU_ADD;
      3'b100:  alu_dec = ALU_XOR;
      3'b110:  alu_dec = ALU_OR;
      3'b111:  alu_dec = ALU_AND;
      3'b010:  alu_dec = ALU_SLT;
      default: alu_dec = ALU_ADD;
    endcase
  endfunction

  always_comb begin
    state_next = state;
    PCWrite    = 1'b0;
    AdrSrc     = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ALUControl = ALU_ADD;
    illegal    = 1'b0;
    retire     = 1'b0;
    ImmSrc     = imm_src_dec(opcode);

    case (state)
      S_FETCH: begin
        // PC + 4 goes straight back into the PC while the IR captures memory.
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = mem_ready;
        PCWrite   = mem_ready;
        if (mem_ready) state_next = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (opcode)
          OP_LOAD, OP_STORE: state_next = S_MEMADR;
          OP_RTYPE:          state_next = S_EXECR;
          OP_ITYPE:          state_next = S_EXECI;
          OP_BRANCH:         state_next = S_BRANCH;
          OP_JAL:            state_next = S_JAL;
          OP_LUI:            state_next = S_LUI;
          default: begin
            illegal    = 1'b1;
            state_next = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        // Loads and stores share MEMADR; bit 5 of the opcode splits them.
        state_next = instr[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
        if (mem_ready) state_next = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc  = 2'b01;
        RegWrite   = 1'b1;
        retire     = 1'b1;
        state_next = S_FETCH;
      end
      S_MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
        if (mem_ready) begin
          retire     = 1'b1;
          state_next = S_FETCH;
        end
      end
      S_EXECR: begin
        ALUSrcA    = 2'b10;
        ALUControl = alu_dec(funct3, instr[30]);
        state_next = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ALUControl = alu_dec(funct3, 1'b0);
        state_next = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite   = 1'b1;
        retire     = 1'b1;
        state_next = S_FETCH;
      end
      S_BRANCH: begin
        // Compare rs1 - rs2; the target was already latched during DECODE.
        ALUSrcA    = 2'b10;
        ALUControl = ALU_SUB;
        case (funct3)
          3'b000:  PCWrite = Zero;
          3'b001:  PCWrite = ~Zero;
          default: PCWrite = 1'b0;
        endcase
        retire     = 1'b1;
        state_next = S_FETCH;
      end
      S_JAL: begin
        // Jump to the DECODE-computed target while the ALU forms OldPC + 4
        // as the link value written back in ALUWB.
        ALUSrcA    = 2'b01;
        ALUSrcB    = 2'b10;
        PCWrite    = 1'b1;
        state_next = S_ALUWB;
      end
      S_LUI: begin
        ResultSrc  = 2'b11;
        RegWrite   = 1'b1;
        retire     = 1'b1;
        state_next = S_FETCH;
      end
      default: state_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_FETCH;
      instret_q <= '0;
    end else begin
      state <= state_next;
      if (retire) instret_q <= instret_q + DATA_WIDTH'(1);
    end
  end

  assign instret = instret_q;

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] instr;
  logic          Zero;
  logic          mem_ready;
  logic          PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal;
  logic [1:0]    ResultSrc, ALUSrcA, ALUSrcB;
  logic [2:0]    ALUControl, ImmSrc;
  logic [DW-1:0] instret;

  multicycle_control #(.DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .Zero(Zero), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUControl(ALUControl), .ImmSrc(ImmSrc), .illegal(illegal), .instret(instret)
  );

  always #5 clk = ~clk;

  logic [17:0] obs;
  assign obs = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
                ALUSrcA, ALUSrcB, ALUControl, ImmSrc, illegal};

  typedef struct packed {
    logic        mr;
    logic        z;
    logic [17:0] exp;
  } step_t;

  step_t         sb[$];
  int            total = 0;
  int            bad = 0;
  logic [DW-1:0] exp_ir = '0;

  // Expected output vector for one cycle, fields in the order of obs.
  function automatic logic [17:0] v(input logic pcw, input logic adr, input logic mw,
                                    input logic irw, input logic rw, input logic [1:0] rs,
                                    input logic [1:0] asa, input logic [1:0] asb,
                                    input logic [2:0] alu, input logic [2:0] imm,
                                    input logic ill);
    return {pcw, adr, mw, irw, rw, rs, asa, asb, alu, imm, ill};
  endfunction

  function automatic logic [17:0] e_fetch(input logic [2:0] imm, input logic mr);
    return v(mr, 0, 0, mr, 0, 2'b10, 2'b00, 2'b10, 3'b000, imm, 0);
  endfunction
  function automatic logic [17:0] e_decode(input logic [2:0] imm, input logic ill);
    return v(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, imm, ill);
  endfunction
  function automatic logic [17:0] e_memadr(input logic [2:0] imm);
    return v(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, imm, 0);
  endfunction
  function automatic logic [17:0] e_memread();
    return v(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0);
  endfunction
  function automatic logic [17:0] e_memwb();
    return v(0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 3'b000, 3'b000, 0);
  endfunction
  function automatic logic [17:0] e_memwrite();
    return v(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b001, 0);
  endfunction
  function automatic logic [17:0] e_exec(input logic [1:0] asb, input logic [2:0] alu);
    return v(0, 0, 0, 0, 0, 2'b00, 2'b10, asb, alu, 3'b000, 0);
  endfunction
  function automatic logic [17:0] e_aluwb(input logic [2:0] imm);
    return v(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, imm, 0);
  endfunction
  function automatic logic [17:0] e_branch(input logic pcw);
    return v(pcw, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 3'b010, 0);
  endfunction

  task automatic push(input logic mr, input logic z, input logic [17:0] e);
    step_t s;
    s.mr = mr; s.z = z; s.exp = e;
    sb.push_back(s);
  endtask

  // Replays queued cycles: drive inputs, sample at the falling edge, compare.
  task automatic drain(input string nm);
    step_t s;
    int    n = 0;
    while (sb.size() > 0) begin
      s = sb.pop_front();
      mem_ready = s.mr;
      Zero      = s.z;
      @(negedge clk);
      total++;
      if (obs !== s.exp) begin
        bad++;
        $display("FAIL %s cycle%0d outputs got=%05h expected=%05h", nm, n, obs, s.exp);
      end
      n++;
      @(posedge clk); #1;
    end
  endtask

  task automatic run_r(input string nm, input logic [31:0] ins, input logic [2:0] alu);
    instr = ins;
    push(1, 0, e_fetch(3'b000, 1));
    push(1, 0, e_decode(3'b000, 0));
    push(1, 0, e_exec(2'b00, alu));
    push(1, 0, e_aluwb(3'b000));
    drain(nm);
    exp_ir++;
    total++;
    if (instret !== exp_ir) begin
      bad++; $display("FAIL %s instret got=%0d expected=%0d", nm, instret, exp_ir);
    end
  endtask

  task automatic run_i(input string nm, input logic [31:0] ins, input logic [2:0] alu);
    instr = ins;
    push(1, 0, e_fetch(3'b000, 1));
    push(1, 0, e_decode(3'b000, 0));
    push(1, 0, e_exec(2'b01, alu));
    push(1, 0, e_aluwb(3'b000));
    drain(nm);
    exp_ir++;
    total++;
    if (instret !== exp_ir) begin
      bad++; $display("FAIL %s instret got=%0d expected=%0d", nm, instret, exp_ir);
    end
  endtask

  task automatic run_br(input string nm, input logic [31:0] ins, input logic z, input logic pcw);
    instr = ins;
    push(1, ~z, e_fetch(3'b010, 1));
    push(1, ~z, e_decode(3'b010, 0));
    push(1, z, e_branch(pcw));
    drain(nm);
    exp_ir++;
    total++;
    if (instret !== exp_ir) begin
      bad++; $display("FAIL %s instret got=%0d expected=%0d", nm, instret, exp_ir);
    end
  endtask

  task automatic run_lui(input string nm);
    instr = 32'h123452B7;
    push(1, 0, e_fetch(3'b011, 1));
    push(1, 0, e_decode(3'b011, 0));
    push(1, 0, v(0, 0, 0, 0, 1, 2'b11, 2'b00, 2'b00, 3'b000, 3'b011, 0));
    drain(nm);
    exp_ir++;
  endtask

  task automatic test_reset();
    instr = '0; Zero = 0; mem_ready = 0; rst_n = 0;
    #12;
    total++;
    if (instret !== '0) begin
      bad++; $display("FAIL reset_instret got=%0d expected=0", instret);
    end
    total++;
    if (obs !== e_fetch(3'b000, 0)) begin
      bad++; $display("FAIL reset_outputs got=%05h expected=%05h", obs, e_fetch(3'b000, 0));
    end
    mem_ready = 1; #1;
    total++;
    if (obs !== e_fetch(3'b000, 1)) begin
      bad++; $display("FAIL reset_fetch_ready got=%05h expected=%05h", obs, e_fetch(3'b000, 1));
    end
    @(posedge clk); #1;
    total++;
    if (obs !== e_fetch(3'b000, 1)) begin
      bad++; $display("FAIL reset_hold got=%05h expected=%05h", obs, e_fetch(3'b000, 1));
    end
    @(negedge clk); rst_n = 1; mem_ready = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_alu_ops();
    run_r("add", 32'h002081B3, 3'b000);
    run_r("sub", 32'h402081B3, 3'b001);
    run_r("and", 32'h0020F1B3, 3'b010);
    run_r("or",  32'h0020E1B3, 3'b011);
    run_r("slt", 32'h0020A1B3, 3'b101);
    run_i("addi_b30", 32'h40008093, 3'b000);
    run_i("xori", 32'h0040C093, 3'b100);
  endtask

  task automatic test_lw();
    instr = 32'h0040A283;
    push(1, 0, e_fetch(3'b000, 1));
    push(1, 0, e_decode(3'b000, 0));
    push(1, 0, e_memadr(3'b000));
    push(0, 0, e_memread());
    push(0, 0, e_memread());
    push(1, 0, e_memread());
    push(1, 0, e_memwb());
    drain("lw_stall");
    exp_ir++;
    total++;
    if (instret !== exp_ir) begin
      bad++; $display("FAIL lw instret got=%0d expected=%0d", instret, exp_ir);
    end
  endtask

  task automatic test_sw();
    instr = 32'h0020A223;
    push(1, 0, e_fetch(3'b001, 1));
    push(1, 0, e_decode(3'b001, 0));
    push(1, 0, e_memadr(3'b001));
    push(1, 0, e_memwrite());
    drain("sw");
    exp_ir++;
    push(0, 0, e_fetch(3'b001, 0));
    push(1, 0, e_fetch(3'b001, 1));
    push(1, 0, e_decode(3'b001, 0));
    push(1, 0, e_memadr(3'b001));
    push(0, 0, e_memwrite());
    push(0, 0, e_memwrite());
    push(1, 0, e_memwrite());
    drain("sw_stall");
    exp_ir++;
    total++;
    if (instret !== exp_ir) begin
      bad++; $display("FAIL sw instret got=%0d expected=%0d", instret, exp_ir);
    end
  endtask

  task automatic test_branch();
    run_br("beq_taken", 32'h00208463, 1, 1);
    run_br("beq_not",   32'h00208463, 0, 0);
    run_br("bne_taken", 32'h00209463, 0, 1);
    run_br("bne_not",   32'h00209463, 1, 0);
    run_br("blt_z1",    32'h0020C463, 1, 0);
  endtask

  task automatic test_jal_lui();
    instr = 32'h008000EF;
    push(1, 0, e_fetch(3'b100, 1));
    push(1, 0, e_decode(3'b100, 0));
    push(1, 0, v(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'b000, 3'b100, 0));
    push(1, 0, e_aluwb(3'b100));
    drain("jal");
    exp_ir++;
    run_lui("lui");
    total++;
    if (instret !== exp_ir) begin
      bad++; $display("FAIL jal_lui instret got=%0d expected=%0d", instret, exp_ir);
    end
  endtask

  task automatic test_illegal();
    instr = 32'h0000007F;
    push(1, 0, e_fetch(3'b000, 1));
    push(1, 0, e_decode(3'b000, 1));
    push(0, 0, e_fetch(3'b000, 0));
    drain("illegal");
    total++;
    if (instret !== exp_ir) begin
      bad++; $display("FAIL illegal instret got=%0d expected=%0d", instret, exp_ir);
    end
  endtask

  task automatic test_back_to_back();
    run_lui("b2b_lui");
    run_r("b2b_add", 32'h002081B3, 3'b000);
    run_lui("b2b_lui2");
    total++;
    if (instret !== exp_ir) begin
      bad++; $display("FAIL b2b instret got=%0d expected=%0d", instret, exp_ir);
    end
  endtask

  task automatic test_reset_mid();
    instr = 32'h0020A223;
    push(1, 0, e_fetch(3'b001, 1));
    push(1, 0, e_decode(3'b001, 0));
    push(1, 0, e_memadr(3'b001));
    drain("rst_mid_pre");
    mem_ready = 0;
    #2;
    total++;
    if (MemWrite !== 1'b1) begin
      bad++; $display("FAIL rst_mid_memwrite_before got=%b expected=1", MemWrite);
    end
    rst_n = 0;
    #1;
    total++;
    if (obs !== e_fetch(3'b001, 0)) begin
      bad++; $display("FAIL rst_mid_outputs got=%05h expected=%05h", obs, e_fetch(3'b001, 0));
    end
    total++;
    if (instret !== '0) begin
      bad++; $display("FAIL rst_mid_instret got=%0d expected=0", instret);
    end
    exp_ir = '0;
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    run_lui("post_rst_lui");
    total++;
    if (instret !== exp_ir) begin
      bad++; $display("FAIL post_rst instret got=%0d expected=%0d", instret, exp_ir);
    end
  endtask

  task automatic test_wrap();
    mem_ready = 0;
    @(negedge clk);
    dut.instret_q = '1;
    @(posedge clk); #1;
    total++;
    if (instret !== {DW{1'b1}}) begin
      bad++; $display("FAIL wrap_preload got=%h expected=ffffffff", instret);
    end
    run_lui("wrap_lui");
    total++;
    if (instret !== '0) begin
      bad++; $display("FAIL wrap instret got=%h expected=0", instret);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_alu_ops();
    test_lw();
    test_sw();
    test_branch();
    test_jal_lui();
    test_illegal();
    test_back_to_back();
    test_reset_mid();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
